ex_muldiv: RTL and testbench

Execute-stage multiply/divide unit with the architectural HI/LO register pair. Sits directly downstream of the ID/EX pipeline register. It consumes the EX-stage operands and a decoded mul/div opcode, and performs MULT/MULTU in one cycle and DIV/DIVU iteratively. While a divide is in progress it raises a stall request to the hazard unit. It supplies HI/LO to MFHI/MFLO in EX.

---
 rtl/ex_muldiv_pkg.sv | 18 +
 rtl/div_radix2_core.sv | 36 +++
 rtl/ex_muldiv.sv | 102 ++++++++++
 tb/tb_ex_muldiv.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: opcodes, FSM states and constants shared by the mul/div unit
package ex_muldiv_pkg;
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;
    localparam int DIV_ITERS = 32;
endpackage

// File: rtl/div_radix2_core.sv
// div_radix2_core: unsigned restoring divider, one quotient bit per step
module div_radix2_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q_next,
    output logic [31:0] r_next
);
    logic [31:0] rem, quo, dvs;
    logic [32:0] sh, diff;
    // next partial remainder/quotient; a borrow in bit 32 means restore
    always_comb begin
        sh     = {rem, quo[31]};
        diff   = sh - {1'b0, dvs};
        q_next = {quo[30:0], ~diff[32]};
        r_next = diff[32] ? sh[31:0] : diff[31:0];
    end
    // load operands on start, then shift one bit per step
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (start) begin
            rem <= '0;
            quo <= a;
            dvs <= b;
        end else if (step) begin
            rem <= r_next;
            quo <= q_next;
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multiply/divide unit with HI/LO; optional MULDIV_DIV_ZERO_FAST_EN finishes divide-by-zero in the accept cycle
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flushE,
    input  md_op_t      opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    output logic        stall_req,
    output logic        busy,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    md_state_t   state;
    logic [4:0]  count;
    logic        neg_q, neg_r;
    logic [31:0] hi, lo;
    logic        is_div, sgn, fast_zero, start, step;
    logic        nq_now, nr_now;
    logic [31:0] a_mag, b_mag, q_next, r_next, q_fix, r_fix, fq_fix, fr_fix;
    logic [63:0] prod;
`ifdef MULDIV_DIV_ZERO_FAST_EN
    assign fast_zero = srcbE == 32'd0;
`else
    assign fast_zero = 1'b0;
`endif
    // operand decode, magnitudes, product and sign fixups
    always_comb begin
        is_div = opE == MD_DIV || opE == MD_DIVU;
        sgn    = opE == MD_DIV || opE == MD_MULT;
        a_mag  = (sgn && srcaE[31]) ? 32'd0 - srcaE : srcaE;
        b_mag  = (sgn && srcbE[31]) ? 32'd0 - srcbE : srcbE;
        nq_now = sgn && (srcaE[31] ^ srcbE[31]);
        nr_now = sgn && srcaE[31];
        prod   = {{32{sgn & srcaE[31]}}, srcaE} * {{32{sgn & srcbE[31]}}, srcbE};
        q_fix  = neg_q ? 32'd0 - q_next : q_next;
        r_fix  = neg_r ? 32'd0 - r_next : r_next;
        fq_fix = nq_now ? 32'd1 : 32'hFFFF_FFFF;
        fr_fix = nr_now ? 32'd0 - a_mag : a_mag;
    end
    // stall covers the accept cycle and every RUN cycle
    always_comb begin
        stall_req = state == ST_RUN || (state == ST_IDLE && is_div && !fast_zero);
        busy      = state == ST_RUN;
        start     = state == ST_IDLE && is_div && !fast_zero && !flushE;
        step      = state == ST_RUN && !flushE;
        hi_o      = hi;
        lo_o      = lo;
    end
    div_radix2_core u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .step   (step),
        .a      (a_mag),
        .b      (b_mag),
        .q_next (q_next),
        .r_next (r_next)
    );
    // FSM and HI/LO updates; DONE ignores opE so a held divide cannot restart
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == ST_IDLE) begin
            if (!flushE) begin
                if (opE == MD_MULT || opE == MD_MULTU) {hi, lo} <= prod;
                if (opE == MD_MTHI) hi <= srcaE;
                if (opE == MD_MTLO) lo <= srcaE;
                if (is_div && fast_zero) begin
                    hi <= fr_fix;
                    lo <= fq_fix;
                end
                if (start) begin
                    state <= ST_RUN;
                    count <= '0;
                    neg_q <= nq_now;
                    neg_r <= nr_now;
                end
            end
        end else if (state == ST_RUN) begin
            if (flushE) begin
                state <= ST_IDLE;
            end else begin
                count <= count + 5'd1;
                if (count == 5'(DIV_ITERS - 1)) begin
                    hi    <= r_fix;
                    lo    <= q_fix;
                    state <= ST_DONE;
                end
            end
        end else begin
            state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flushE = 1'b0;
    md_op_t      opE = MD_NONE;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        stall_req, busy;
    logic [31:0] hi_o, lo_o;
    int          checks = 0;
    int          errors = 0;
    int          n;
`ifdef MULDIV_DIV_ZERO_FAST_EN
    localparam int ZERO_STALLS = 0;
`else
    localparam int ZERO_STALLS = 33;
`endif

    ex_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .flushE    (flushE),
        .opE       (opE),
        .srcaE     (srcaE),
        .srcbE     (srcbE),
        .stall_req (stall_req),
        .busy      (busy),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        opE   = op;
        srcaE = a;
        srcbE = b;
    endtask

    // holds the op while stalled; returns at the negedge of the first non-stall cycle
    task automatic do_div(input md_op_t op, input logic [31:0] a, input logic [31:0] b, output int cnt);
        issue(op, a, b);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_req) break;
            cnt++;
            next_cycle();
        end
    endtask

    initial begin
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        next_cycle();
        rst = 1'b0;

        issue(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        @(negedge clk);
        chk("mult_stall", {31'd0, stall_req}, 32'd0);
        next_cycle();
        issue(MD_NONE, 32'h0, 32'h0);
        @(negedge clk);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFFA);
        next_cycle();

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        next_cycle();
        issue(MD_NONE, 32'h0, 32'h0);
        @(negedge clk);
        chk("multu_hi", hi_o, 32'h0000_0001);
        chk("multu_lo", lo_o, 32'hFFFF_FFFE);
        next_cycle();

        do_div(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, n);
        chk("div_stalls", n, 32'd33);
        chk("div_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_hi", hi_o, 32'hFFFF_FFFF);
        chk("div_done_busy", {31'd0, busy}, 32'd0);
        next_cycle();
        issue(MD_NONE, 32'h0, 32'h0);

        do_div(MD_DIV, 32'h0000_0007, 32'hFFFF_FFFE, n);
        chk("div2_stalls", n, 32'd33);
        chk("div2_lo", lo_o, 32'hFFFF_FFFD);
        chk("div2_hi", hi_o, 32'h0000_0001);
        next_cycle();
        issue(MD_NONE, 32'h0, 32'h0);

        do_div(MD_DIVU, 32'd100, 32'd7, n);
        chk("divu_stalls", n, 32'd33);
        chk("divu_lo", lo_o, 32'd14);
        chk("divu_hi", hi_o, 32'd2);
        next_cycle();
        issue(MD_NONE, 32'h0, 32'h0);
        @(negedge clk);
        chk("divu_mflo", lo_o, 32'd14);
        chk("divu_idle_stall", {31'd0, stall_req}, 32'd0);
        next_cycle();

        issue(MD_MTHI, 32'h5, 32'h0);
        next_cycle();
        issue(MD_MTLO, 32'h5, 32'h0);
        next_cycle();
        issue(MD_DIVU, 32'd100, 32'd7);
        next_cycle();
        repeat (9) next_cycle();
        @(negedge clk);
        chk("flush_run_busy", {31'd0, busy}, 32'd1);
        flushE = 1'b1;
        next_cycle();
        flushE = 1'b0;
        issue(MD_NONE, 32'h0, 32'h0);
        @(negedge clk);
        chk("flush_stall", {31'd0, stall_req}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", hi_o, 32'h5);
        chk("flush_lo", lo_o, 32'h5);
        next_cycle();

        issue(MD_DIVU, 32'd100, 32'd7);
        next_cycle();
        repeat (9) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        issue(MD_NONE, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_run_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_run_busy", {31'd0, busy}, 32'd0);
        chk("rst_run_hi", hi_o, 32'h0);
        chk("rst_run_lo", lo_o, 32'h0);
        next_cycle();

        do_div(MD_DIVU, 32'h0000_1234, 32'h0, n);
        chk("dz_stalls", n, ZERO_STALLS);
        next_cycle();
        issue(MD_NONE, 32'h0, 32'h0);
        @(negedge clk);
        chk("dz_lo", lo_o, 32'hFFFF_FFFF);
        chk("dz_hi", hi_o, 32'h0000_1234);
        next_cycle();

        do_div(MD_DIV, 32'hFFFF_FFF9, 32'h0, n);
        chk("sdz_stalls", n, ZERO_STALLS);
        next_cycle();
        issue(MD_NONE, 32'h0, 32'h0);
        @(negedge clk);
        chk("sdz_lo", lo_o, 32'h0000_0001);
        chk("sdz_hi", hi_o, 32'hFFFF_FFF9);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
